// File: rtl/qstate_reader_if.sv
// Read-out bus of the quantum state register bank: control inputs, the state vector
// and the valid/ready amplitude stream towards the sink.
interface qstate_reader_if #(
    parameter int N      = 1,
    parameter int DATA_W = 32
);
    localparam int AMPS  = 2 ** N;
    localparam int VEC_W = AMPS * DATA_W * 2;
    localparam int MAG_W = 2 * DATA_W + 1;

    logic             start;
    logic             abort;
    logic [VEC_W-1:0] S;
    logic             out_valid;
    logic             out_ready;
    logic [DATA_W-1:0] out_re;
    logic [DATA_W-1:0] out_im;
    logic [N-1:0]     out_idx;
    logic             out_last;
    logic [MAG_W-1:0] out_mag;
    logic             busy;
    logic             done;

    modport master (
        input  start, abort, S, out_ready,
        output out_valid, out_re, out_im, out_idx, out_last, out_mag, busy, done
    );

    modport slave (
        output start, abort, S, out_ready,
        input  out_valid, out_re, out_im, out_idx, out_last, out_mag, busy, done
    );
endinterface

// File: rtl/qstate_reader.sv
// Snapshots the 2^N-amplitude state vector on start and streams it one amplitude per beat.
// Optional squared-magnitude output is built only when QREAD_MAG_EN is defined.
module qstate_reader #(
    parameter int N      = 1,
    parameter int DATA_W = 32
) (
    input  logic          clk,
    input  logic          rst,
    qstate_reader_if.master bus
);
    localparam int AMPS  = 2 ** N;
    localparam int AMP_W = 2 * DATA_W;
    localparam int VEC_W = AMPS * AMP_W;
    localparam int MAG_W = 2 * DATA_W + 1;
    localparam logic [N-1:0] LAST = N'(AMPS - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                    state_q, state_d;
    logic [N-1:0]              idx_q, idx_d;
    logic                      valid_q, valid_d;
    logic signed [DATA_W-1:0]  re_q, re_d;
    logic signed [DATA_W-1:0]  im_q, im_d;
    logic                      last_q, last_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic [VEC_W-1:0]          shadow_q;
    logic                      capture;
    logic [N-1:0]              next_idx;
    logic [AMP_W-1:0]          cap_amp;
    logic [AMP_W-1:0]          nxt_amp;

    function automatic logic [AMP_W-1:0] amp_of(input logic [VEC_W-1:0] v,
                                                 input logic [N-1:0] i);
        return v[(AMPS - 1 - int'(i)) * AMP_W +: AMP_W];
    endfunction

    assign next_idx = idx_q + 1'b1;
    assign cap_amp  = amp_of(bus.S, '0);
    assign nxt_amp  = amp_of(shadow_q, next_idx);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        re_d    = re_q;
        im_d    = im_q;
        last_d  = last_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        capture = 1'b0;
        // Abort outranks start and any handshake; a beat taken on this edge still counts.
        if (bus.abort) begin
            state_d = IDLE;
            idx_d   = '0;
            valid_d = 1'b0;
            re_d    = '0;
            im_d    = '0;
            last_d  = 1'b0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        capture = 1'b1;
                        state_d = SEND;
                        idx_d   = '0;
                        valid_d = 1'b1;
                        re_d    = $signed(cap_amp[AMP_W-1:DATA_W]);
                        im_d    = $signed(cap_amp[DATA_W-1:0]);
                        last_d  = (LAST == '0);
                        busy_d  = 1'b1;
                    end
                end
                SEND: begin
                    if (valid_q && bus.out_ready) begin
                        if (idx_q == LAST) begin
                            state_d = IDLE;
                            idx_d   = '0;
                            valid_d = 1'b0;
                            re_d    = '0;
                            im_d    = '0;
                            last_d  = 1'b0;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            idx_d  = next_idx;
                            re_d   = $signed(nxt_amp[AMP_W-1:DATA_W]);
                            im_d   = $signed(nxt_amp[DATA_W-1:0]);
                            last_d = (next_idx == LAST);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            valid_q <= 1'b0;
            re_q    <= '0;
            im_q    <= '0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            re_q    <= re_d;
            im_q    <= im_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Shadow is only read after a capture, so it needs no reset.
    always_ff @(posedge clk) begin
        if (capture) begin
            shadow_q <= bus.S;
        end
    end

`ifdef QREAD_MAG_EN
    logic [MAG_W-1:0] mag_q;

    function automatic logic [MAG_W-1:0] mag_of(input logic signed [DATA_W-1:0] re,
                                                 input logic signed [DATA_W-1:0] im);
        logic signed [AMP_W-1:0] pr;
        logic signed [AMP_W-1:0] pi;
        pr = re * re;
        pi = im * im;
        return MAG_W'($unsigned(pr)) + MAG_W'($unsigned(pi));
    endfunction

    // Follows re_d/im_d, so it shares their latency and holds with them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mag_q <= '0;
        end else begin
            mag_q <= mag_of(re_d, im_d);
        end
    end

    assign bus.out_mag = mag_q;
`else
    assign bus.out_mag = '0;
`endif

    assign bus.out_valid = valid_q;
    assign bus.out_re    = re_q;
    assign bus.out_im    = im_q;
    assign bus.out_idx   = idx_q;
    assign bus.out_last  = last_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule
